// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the mini CPU sequencer and the execute stage.
// Contents: sequencer state encoding, instruction field bit positions,
// IDEN / OPCODE constants, and a HALT-detection helper.
package cpu_pkg;

    // Sequencer FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_IWAIT  = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALTED = 3'd5
    } seq_state_e;

    // Instruction word layout: [15:14] IDEN, [13:10] OPCODE, low bits operand
    localparam int INSTR_W  = 16;
    localparam int IDEN_MSB = 15;
    localparam int IDEN_LSB = 14;
    localparam int OPC_MSB  = 13;
    localparam int OPC_LSB  = 10;

    localparam logic [1:0] IDEN_HALT = 2'b11;
    localparam logic [1:0] IDEN_EXEC = 2'b01;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SHL   = 4'b0011;
    localparam logic [3:0] OP_SHR   = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b1111;

    // True when the IDEN field marks a HALT instruction
    function automatic logic iden_is_halt(input logic [1:0] iden);
        return (iden == IDEN_HALT);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// seq_decode: purely combinational split of the instruction register.
// Ports:
//   ir      in  16      instruction word
//   iden    out 2       IR[15:14]
//   opcode  out 4       IR[13:10]
//   operand out ADDR_W  IR[ADDR_W-1:0]
//   is_halt out 1       IDEN equals HALT
// Bits [9:ADDR_W] are reserved and intentionally ignored.
module seq_decode import cpu_pkg::*; #(
    parameter int ADDR_W = 8
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [1:0]         iden,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  operand,
    output logic               is_halt
);

    logic unused_reserved_s;

    assign iden              = ir[IDEN_MSB:IDEN_LSB];
    assign opcode            = ir[OPC_MSB:OPC_LSB];
    assign operand           = ir[ADDR_W-1:0];
    assign is_halt           = iden_is_halt(ir[IDEN_MSB:IDEN_LSB]);
    assign unused_reserved_s = ^ir[OPC_LSB-1:ADDR_W];

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/decode sequencer for the mini CPU.
// Fetches a word from synchronous IMEM, decodes it, issues the operand read
// to DMEM and pulses EX_START in the cycle the operand is valid.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   RUN, START_PC   start request and first fetch address (IDLE/HALTED only)
//   ABORT           return to IDLE, discarding any in-flight instruction
//   IMEM_RD/ADDR/RDATA   instruction memory interface (1-cycle latency)
//   DMEM_RD/ADDR    operand read to data memory
//   EX_START/IDEN/OPCODE execute-stage interface
//   BUSY, HALTED, PC, RETIRED  status
// All outputs come from flops (state, IR, PC, counters); none depends
// combinationally on an input.
module exec_sequencer import cpu_pkg::*; #(
    parameter int ADDR_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RUN,
    input  logic [ADDR_W-1:0]   START_PC,
    input  logic                ABORT,
    output logic                IMEM_RD,
    output logic [ADDR_W-1:0]   IMEM_ADDR,
    input  logic [INSTR_W-1:0]  IMEM_RDATA,
    output logic                DMEM_RD,
    output logic [ADDR_W-1:0]   DMEM_ADDR,
    output logic                EX_START,
    output logic [1:0]          EX_IDEN,
    output logic [3:0]          EX_OPCODE,
    output logic                BUSY,
    output logic                HALTED,
    output logic [ADDR_W-1:0]   PC,
    output logic [15:0]         RETIRED
);

    seq_state_e          state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [INSTR_W-1:0]  ir_r;
    logic [15:0]         retired_r;
    logic                imem_rd_r;
    logic                dmem_rd_r;
    logic                ex_start_r;
    logic                busy_r;
    logic                halted_r;
    logic                ir_is_halt_s;

    seq_decode #(.ADDR_W(ADDR_W)) u_decode (
        .ir      (ir_r),
        .iden    (EX_IDEN),
        .opcode  (EX_OPCODE),
        .operand (DMEM_ADDR),
        .is_halt (ir_is_halt_s)
    );

    // Sequencer FSM; strobes are set on the edge entering the state they belong to
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            pc_r       <= {ADDR_W{1'b0}};
            ir_r       <= {INSTR_W{1'b0}};
            retired_r  <= 16'd0;
            imem_rd_r  <= 1'b0;
            dmem_rd_r  <= 1'b0;
            ex_start_r <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
        end else if (ABORT) begin
            // PC and RETIRED are kept; the in-flight instruction is dropped
            state_r    <= ST_IDLE;
            imem_rd_r  <= 1'b0;
            dmem_rd_r  <= 1'b0;
            ex_start_r <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            imem_rd_r  <= 1'b0;
            dmem_rd_r  <= 1'b0;
            ex_start_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (RUN) begin
                        pc_r      <= START_PC;
                        retired_r <= 16'd0;
                        state_r   <= ST_FETCH;
                        imem_rd_r <= 1'b1;
                        busy_r    <= 1'b1;
                        halted_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_IWAIT;
                end
                ST_IWAIT: begin
                    // DMEM_RD belongs to DECODE, so decide it from the word
                    // being captured rather than from IR
                    ir_r      <= IMEM_RDATA;
                    state_r   <= ST_DECODE;
                    dmem_rd_r <= !iden_is_halt(IMEM_RDATA[IDEN_MSB:IDEN_LSB]);
                end
                ST_DECODE: begin
                    if (ir_is_halt_s) begin
                        state_r  <= ST_HALTED;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end else begin
                        state_r    <= ST_EXEC;
                        ex_start_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    retired_r <= retired_r + 16'd1;
                    pc_r      <= pc_r + ADDR_W'(1);
                    state_r   <= ST_FETCH;
                    imem_rd_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_RD   = imem_rd_r;
    assign IMEM_ADDR = pc_r;
    assign DMEM_RD   = dmem_rd_r;
    assign EX_START  = ex_start_r;
    assign BUSY      = busy_r;
    assign HALTED    = halted_r;
    assign PC        = pc_r;
    assign RETIRED   = retired_r;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a synchronous IMEM model.
module tb_exec_sequencer;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        run_s;
    logic [7:0]  start_pc_s;
    logic        abort_s;
    logic        imem_rd_s;
    logic [7:0]  imem_addr_s;
    logic [15:0] imem_rdata_r;
    logic        dmem_rd_s;
    logic [7:0]  dmem_addr_s;
    logic        ex_start_s;
    logic [1:0]  ex_iden_s;
    logic [3:0]  ex_opcode_s;
    logic        busy_s;
    logic        halted_s;
    logic [7:0]  pc_s;
    logic [15:0] retired_s;

    logic [15:0] imem [0:255];
    int total = 0;
    int bad   = 0;

    exec_sequencer #(.ADDR_W(8)) dut (
        .CLK        (clk_s),
        .RST        (rst_s),
        .RUN        (run_s),
        .START_PC   (start_pc_s),
        .ABORT      (abort_s),
        .IMEM_RD    (imem_rd_s),
        .IMEM_ADDR  (imem_addr_s),
        .IMEM_RDATA (imem_rdata_r),
        .DMEM_RD    (dmem_rd_s),
        .DMEM_ADDR  (dmem_addr_s),
        .EX_START   (ex_start_s),
        .EX_IDEN    (ex_iden_s),
        .EX_OPCODE  (ex_opcode_s),
        .BUSY       (busy_s),
        .HALTED     (halted_s),
        .PC         (pc_s),
        .RETIRED    (retired_s)
    );

    always #5 clk_s = ~clk_s;

    // Synchronous instruction memory: data valid the cycle after IMEM_RD
    always @(posedge clk_s) begin
        if (imem_rd_s) imem_rdata_r <= imem[imem_addr_s];
    end

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[8'h10] = 16'h4020;   // LOAD @0x20
        imem[8'h11] = 16'h4421;   // ADD  @0x21
        imem[8'h12] = 16'hC000;   // HALT
        imem[8'h30] = 16'h5040;   // SHR  @0x40
        imem[8'h31] = 16'h4C41;   // SHL  @0x41
        imem[8'h32] = 16'h7C42;   // STORE @0x42
        imem[8'h33] = 16'hFFFF;   // HALT with junk in other fields
        imem[8'hFF] = 16'h0AFF;   // IDEN 00, SUB, reserved bits set, @0xFF
        imem[8'h00] = 16'hC000;   // HALT

        rst_s = 1'b1; run_s = 1'b0; abort_s = 1'b0; start_pc_s = 8'h00;
        tick(); tick();
        rst_s = 1'b0;
        chk("rst_busy",    {15'd0, busy_s},     16'd0);
        chk("rst_halted",  {15'd0, halted_s},   16'd0);
        chk("rst_pc",      {8'd0, pc_s},        16'd0);
        chk("rst_retired", retired_s,           16'd0);
        chk("rst_strobes", {13'd0, imem_rd_s, dmem_rd_s, ex_start_s}, 16'd0);
        chk("rst_iden_opc", {10'd0, ex_iden_s, ex_opcode_s}, 16'd0);

        // Program 1: LOAD, ADD, HALT from 0x10
        start_pc_s = 8'h10; run_s = 1'b1;
        tick();
        run_s = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("p1_exstart_c%0d", c), {15'd0, ex_start_s},
                (c == 4 || c == 8) ? 16'd1 : 16'd0);
            if (c == 1) begin
                chk("p1_fetch_rd",   {15'd0, imem_rd_s},  16'd1);
                chk("p1_fetch_addr", {8'd0, imem_addr_s}, 16'h0010);
                chk("p1_busy",       {15'd0, busy_s},     16'd1);
            end
            if (c == 3) begin
                chk("p1_dmem_rd1",   {15'd0, dmem_rd_s},  16'd1);
                chk("p1_dmem_addr1", {8'd0, dmem_addr_s}, 16'h0020);
                chk("p1_iden1",      {14'd0, ex_iden_s},  16'd1);
                chk("p1_opc1",       {12'd0, ex_opcode_s}, 16'd0);
            end
            if (c == 5) chk("p1_pc_after1", {8'd0, pc_s}, 16'h0011);
            if (c == 7) begin
                chk("p1_dmem_addr2", {8'd0, dmem_addr_s}, 16'h0021);
                chk("p1_opc2",       {12'd0, ex_opcode_s}, 16'd1);
            end
            if (c == 11) begin
                chk("p1_halt_no_dmem", {15'd0, dmem_rd_s}, 16'd0);
                chk("p1_halt_iden",    {14'd0, ex_iden_s}, 16'd3);
                chk("p1_not_halted_yet", {15'd0, halted_s}, 16'd0);
            end
            if (c < 12) tick();
        end
        chk("p1_halted",  {15'd0, halted_s}, 16'd1);
        chk("p1_busy_lo", {15'd0, busy_s},   16'd0);
        chk("p1_pc",      {8'd0, pc_s},      16'h0012);
        chk("p1_retired", retired_s,         16'd2);

        // Restart from HALTED at 0x30 with RUN held high throughout BUSY
        start_pc_s = 8'h30; run_s = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c == 1) begin
                chk("p2_retired_clr", retired_s,          16'd0);
                chk("p2_fetch_rd",    {15'd0, imem_rd_s}, 16'd1);
                chk("p2_fetch_addr",  {8'd0, imem_addr_s}, 16'h0030);
            end
            if (c <= 15) chk($sformatf("p2_exstart_c%0d", c), {15'd0, ex_start_s},
                (c == 4 || c == 8 || c == 12) ? 16'd1 : 16'd0);
            if (c == 11) chk("p2_opc_store", {12'd0, ex_opcode_s}, 16'hF);
            if (c == 12) run_s = 1'b0;
            if (c < 16) tick();
        end
        chk("p2_halted",  {15'd0, halted_s}, 16'd1);
        chk("p2_pc",      {8'd0, pc_s},      16'h0033);
        chk("p2_retired", retired_s,         16'd3);

        // PC wrap: 0xFF then HALT at 0x00
        start_pc_s = 8'hFF; run_s = 1'b1;
        tick();
        run_s = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                chk("p3_dmem_addr", {8'd0, dmem_addr_s}, 16'h00FF);
                chk("p3_iden",      {14'd0, ex_iden_s},  16'd0);
                chk("p3_opc",       {12'd0, ex_opcode_s}, 16'd2);
            end
            if (c == 4) chk("p3_exstart", {15'd0, ex_start_s}, 16'd1);
            if (c == 5) chk("p3_pc_wrap", {8'd0, pc_s}, 16'h0000);
            if (c < 8) tick();
        end
        chk("p3_halted", {15'd0, halted_s}, 16'd1);
        chk("p3_pc",     {8'd0, pc_s},      16'h0000);

        // ABORT in DECODE of the second instruction
        start_pc_s = 8'h10; run_s = 1'b1;
        tick();
        run_s = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        chk("ab_no_exstart", {15'd0, ex_start_s}, 16'd0);
        chk("ab_idle_busy",  {15'd0, busy_s},     16'd0);
        chk("ab_halted",     {15'd0, halted_s},   16'd0);
        chk("ab_retired",    retired_s,           16'd1);
        chk("ab_pc",         {8'd0, pc_s},        16'h0011);
        tick();
        chk("ab_still_idle", {14'd0, busy_s, imem_rd_s}, 16'd0);

        // ABORT and RUN together in IDLE: stay IDLE
        abort_s = 1'b1; run_s = 1'b1;
        tick();
        abort_s = 1'b0; run_s = 1'b0;
        chk("abrun_idle", {14'd0, busy_s, imem_rd_s}, 16'd0);
        chk("abrun_pc",   {8'd0, pc_s}, 16'h0011);

        // RST in the DECODE cycle of an instruction
        start_pc_s = 8'h10; run_s = 1'b1;
        tick();
        run_s = 1'b0;
        tick(); tick();
        chk("rs_in_decode", {15'd0, dmem_rd_s}, 16'd1);
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        chk("rs_no_exstart", {15'd0, ex_start_s}, 16'd0);
        chk("rs_flags",      {13'd0, busy_s, halted_s, dmem_rd_s}, 16'd0);
        chk("rs_pc",         {8'd0, pc_s}, 16'd0);
        chk("rs_retired",    retired_s,    16'd1 - 16'd1);
        chk("rs_iden_opc",   {10'd0, ex_iden_s, ex_opcode_s}, 16'd0);
        tick();
        chk("rs_after", {14'd0, ex_start_s, imem_rd_s}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
